// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, grant-source enum and LU result entry for the RF write-back arbiter
package rf_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_W,
        GNT_LU
    } gnt_e;

    typedef struct packed {
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } rf_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - generic power-of-2 deep FIFO holding LU results until the RF write port is granted
module rf_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - RF write-port arbiter between W stage and LU result FIFO, with busy scoreboard
// Optional trace output enabled by defining RF_WB_TRACE_EN.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_wr,
    input  logic [REG_W-1:0]  w_a3,
    input  logic [DATA_W-1:0] w_wd,
    input  logic [DATA_W-1:0] w_pc,
    input  logic              lu_issue,
    input  logic [REG_W-1:0]  lu_issue_a3,
    output logic              issue_ok,
    input  logic              lu_valid,
    input  logic [REG_W-1:0]  lu_a3,
    input  logic [DATA_W-1:0] lu_wd,
    input  logic [DATA_W-1:0] lu_pc,
    output logic              lu_ready,
    input  logic [REG_W-1:0]  q_a1,
    input  logic [REG_W-1:0]  q_a2,
    output logic              q_busy1,
    output logic              q_busy2,
    output logic              pipe_stall,
    output logic              rf_wr,
    output logic [REG_W-1:0]  rf_a3,
    output logic [DATA_W-1:0] rf_wd,
    output logic [DATA_W-1:0] rf_pc
);

    localparam int SW = $clog2(STARVE_LIM + 1);

    rf_entry_t        push_entry;
    rf_entry_t        head;
    logic             full, empty, push, pop;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [SW-1:0]    starve_q, starve_d;
    gnt_e             gnt;

    assign push_entry = '{a3: lu_a3, wd: lu_wd, pc: lu_pc};
    assign lu_ready   = !reset && !full;
    assign push       = lu_valid && lu_ready;
    assign pipe_stall = !reset && !empty && (starve_q == SW'(STARVE_LIM));
    assign issue_ok   = !reset && ((lu_issue_a3 == '0) || !busy_q[lu_issue_a3]);
    assign q_busy1    = (q_a1 != '0) && busy_q[q_a1];
    assign q_busy2    = (q_a2 != '0) && busy_q[q_a2];
    assign pop        = (gnt == GNT_LU);

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(rf_entry_t))
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head)
    );

    always_comb begin
        gnt      = GNT_NONE;
        starve_d = starve_q;
        if (!reset) begin
            if (pipe_stall) begin
                gnt = GNT_LU;
            end else if (w_wr && (w_a3 != '0)) begin
                gnt = GNT_W;
                if (!empty) begin
                    starve_d = starve_q + 1'b1;
                end
            end else if (!empty) begin
                gnt = GNT_LU;
            end
        end
        if (gnt == GNT_LU) begin
            starve_d = '0;
        end
    end

    // An LU entry targeting $0 is still popped, but never reaches the RF.
    always_comb begin
        rf_wr = 1'b0;
        rf_a3 = '0;
        rf_wd = '0;
        rf_pc = '0;
        case (gnt)
            GNT_W: begin
                rf_wr = 1'b1;
                rf_a3 = w_a3;
                rf_wd = w_wd;
                rf_pc = w_pc;
            end
            GNT_LU: begin
                rf_wr = (head.a3 != '0);
                rf_a3 = head.a3;
                rf_wd = head.wd;
                rf_pc = head.pc;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head.a3] = 1'b0;
        end
        if (lu_issue && issue_ok && (lu_issue_a3 != '0)) begin
            busy_d[lu_issue_a3] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= '0;
            starve_q <= '0;
        end else begin
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

`ifdef RF_WB_TRACE_EN
    always @(posedge clk) begin
        if (!reset && rf_wr) begin
            $display("%0t@%h: $%0d <= %h [%s]", $time, rf_pc, rf_a3, rf_wd,
                     (gnt == GNT_W) ? "W" : "LU");
        end
        if (pipe_stall) begin
            $display("STARVE stall @%0t", $time);
        end
    end
`else
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        w_wr;
    logic [4:0]  w_a3;
    logic [31:0] w_wd;
    logic [31:0] w_pc;
    logic        lu_issue;
    logic [4:0]  lu_issue_a3;
    logic        issue_ok;
    logic        lu_valid;
    logic [4:0]  lu_a3;
    logic [31:0] lu_wd;
    logic [31:0] lu_pc;
    logic        lu_ready;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_busy1;
    logic        q_busy2;
    logic        pipe_stall;
    logic        rf_wr;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] rf_pc;

    int n_checks = 0;
    int n_errors = 0;

    rf_wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .w_wr        (w_wr),
        .w_a3        (w_a3),
        .w_wd        (w_wd),
        .w_pc        (w_pc),
        .lu_issue    (lu_issue),
        .lu_issue_a3 (lu_issue_a3),
        .issue_ok    (issue_ok),
        .lu_valid    (lu_valid),
        .lu_a3       (lu_a3),
        .lu_wd       (lu_wd),
        .lu_pc       (lu_pc),
        .lu_ready    (lu_ready),
        .q_a1        (q_a1),
        .q_a2        (q_a2),
        .q_busy1     (q_busy1),
        .q_busy2     (q_busy2),
        .pipe_stall  (pipe_stall),
        .rf_wr       (rf_wr),
        .rf_a3       (rf_a3),
        .rf_wd       (rf_wd),
        .rf_pc       (rf_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle();
        w_wr = 0; w_a3 = 0; w_wd = 0; w_pc = 0;
        lu_issue = 0; lu_issue_a3 = 0;
        lu_valid = 0; lu_a3 = 0; lu_wd = 0; lu_pc = 0;
        q_a1 = 0; q_a2 = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        settle();
        check("rst_rf_wr", 32'(rf_wr), 0);
        check("rst_stall", 32'(pipe_stall), 0);
        check("rst_lu_ready", 32'(lu_ready), 0);
        check("rst_issue_ok", 32'(issue_ok), 0);

        step();
        reset = 0;
        q_a1 = 8;
        settle();
        check("post_rst_lu_ready", 32'(lu_ready), 1);
        check("post_rst_issue_ok", 32'(issue_ok), 1);
        check("post_rst_q_busy1", 32'(q_busy1), 0);
        check("post_rst_rf_wr", 32'(rf_wr), 0);

        // Scoreboard set and refused re-issue
        lu_issue = 1; lu_issue_a3 = 8;
        #1;
        check("issue8_ok", 32'(issue_ok), 1);
        step();
        settle();
        check("busy8_q1", 32'(q_busy1), 1);
        check("reissue8_ok", 32'(issue_ok), 0);
        lu_issue_a3 = 0;
        #1;
        check("issue_r0_ok", 32'(issue_ok), 1);

        // LU result write-back with idle pipeline
        step();
        lu_issue = 0;
        lu_valid = 1; lu_a3 = 8; lu_wd = 32'h1234; lu_pc = 32'h100;
        settle();
        check("lu8_ready", 32'(lu_ready), 1);
        check("lu8_push_cycle_wr", 32'(rf_wr), 0);
        step();
        lu_valid = 0;
        settle();
        check("lu8_wr", 32'(rf_wr), 1);
        check("lu8_a3", 32'(rf_a3), 8);
        check("lu8_wd", rf_wd, 32'h1234);
        check("lu8_pc", rf_pc, 32'h100);
        check("lu8_no_bypass", 32'(q_busy1), 1);
        step();
        settle();
        check("lu8_after_wr", 32'(rf_wr), 0);
        check("lu8_cleared", 32'(q_busy1), 0);

        // Starvation: W writes every cycle, one LU entry queued
        step();
        w_wr = 1; w_a3 = 5; w_wd = 32'h55; w_pc = 32'h200;
        lu_issue = 1; lu_issue_a3 = 9;
        lu_valid = 1; lu_a3 = 9; lu_wd = 32'hAAAA; lu_pc = 32'h300;
        q_a1 = 9;
        settle();
        check("starve_push_a3", 32'(rf_a3), 5);
        step();
        lu_issue = 0;
        lu_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("starve_w_stall", 32'(pipe_stall), 0);
            check("starve_w_a3", 32'(rf_a3), 5);
            step();
        end
        settle();
        check("starve_stall", 32'(pipe_stall), 1);
        check("starve_lu_wr", 32'(rf_wr), 1);
        check("starve_lu_a3", 32'(rf_a3), 9);
        check("starve_lu_wd", rf_wd, 32'hAAAA);
        check("starve_busy9", 32'(q_busy1), 1);
        step();
        settle();
        check("starve_release", 32'(pipe_stall), 0);
        check("starve_w_resume", 32'(rf_a3), 5);
        check("starve_busy9_clr", 32'(q_busy1), 0);

        // Fill the FIFO under continuous W writes
        step();
        for (int i = 0; i < 4; i++) begin
            lu_valid = 1; lu_a3 = 5'(10 + i); lu_wd = 32'h100 + 32'(i); lu_pc = 32'h400 + 32'(i);
            settle();
            check("fill_ready", 32'(lu_ready), 1);
            check("fill_w_a3", 32'(rf_a3), 5);
            step();
        end
        lu_a3 = 14; lu_wd = 32'h104; lu_pc = 32'h404;
        settle();
        check("full_ready", 32'(lu_ready), 0);
        check("full_stall", 32'(pipe_stall), 1);
        check("full_pop_a3", 32'(rf_a3), 10);
        check("full_pop_wd", rf_wd, 32'h100);
        step();
        settle();
        check("held_ready", 32'(lu_ready), 1);
        check("held_stall", 32'(pipe_stall), 0);
        check("held_w_a3", 32'(rf_a3), 5);
        step();
        lu_valid = 0;
        w_wr = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("drain_wr", 32'(rf_wr), 1);
            check("drain_a3", 32'(rf_a3), 32'(11 + i));
            check("drain_wd", rf_wd, 32'h101 + 32'(i));
            step();
        end
        settle();
        check("drain_empty", 32'(rf_wr), 0);

        // Entry targeting $0 is popped without a write
        step();
        lu_valid = 1; lu_a3 = 0; lu_wd = 32'hDEAD; lu_pc = 32'h500;
        settle();
        step();
        lu_a3 = 7; lu_wd = 32'h77; lu_pc = 32'h504;
        settle();
        check("a3zero_wr", 32'(rf_wr), 0);
        step();
        lu_valid = 0;
        q_a1 = 0;
        settle();
        check("after_zero_wr", 32'(rf_wr), 1);
        check("after_zero_a3", 32'(rf_a3), 7);
        check("after_zero_wd", rf_wd, 32'h77);
        check("q_busy_r0", 32'(q_busy1), 0);

        // Reset with two entries queued and busy[3], busy[9] set
        step();
        w_wr = 1; w_a3 = 5; w_wd = 32'h66; w_pc = 32'h600;
        lu_issue = 1; lu_issue_a3 = 3;
        lu_valid = 1; lu_a3 = 3; lu_wd = 32'h33; lu_pc = 32'h700;
        settle();
        check("rq_w_a3_0", 32'(rf_a3), 5);
        step();
        lu_issue_a3 = 9;
        lu_a3 = 9; lu_wd = 32'h99; lu_pc = 32'h704;
        settle();
        check("rq_issue9_ok", 32'(issue_ok), 1);
        check("rq_w_a3_1", 32'(rf_a3), 5);
        step();
        lu_issue = 0;
        lu_valid = 0;
        q_a1 = 3; q_a2 = 9;
        settle();
        check("rq_busy3", 32'(q_busy1), 1);
        check("rq_busy9", 32'(q_busy2), 1);
        reset = 1;
        #1;
        check("rq_in_rst_wr", 32'(rf_wr), 0);
        check("rq_in_rst_stall", 32'(pipe_stall), 0);
        step();
        reset = 0;
        w_wr = 0;
        settle();
        check("rq_after_wr", 32'(rf_wr), 0);
        check("rq_after_busy3", 32'(q_busy1), 0);
        check("rq_after_busy9", 32'(q_busy2), 0);
        check("rq_after_ready", 32'(lu_ready), 1);
        step();
        settle();
        check("rq_never_written", 32'(rf_wr), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
